// File: rtl/trap_ctrl.sv
// Trap/return sequencer: arbitrates exceptions, mret and the machine timer irq,
// strobes the CSR file, flushes the pipeline and holds a fetch redirect. Option: TRAP_CTRL_VECTORED_EN.
module trap_ctrl #(
  parameter int XLEN     = 32,
  parameter int MTI_CODE = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_req,
  input  logic            irq_pc_valid,
  input  logic [XLEN-1:0] irq_pc,
  input  logic            timer_interrupt,
  input  logic            mie_mtie,
  input  logic            mstatus_mie,
  input  logic [1:0]      priv_mode,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            trap_enter,
  output logic [XLEN-1:0] trap_cause,
  output logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] trap_val,
  output logic            mret_exec,
  output logic            flush,
  output logic            busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready
);

  typedef enum logic [1:0] {IDLE, TRAP, MRET, REDIRECT} state_t;
  state_t state;

  logic            irq_take;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] trap_target;

  // Interrupts are always enabled while running in U-mode, regardless of MIE.
  assign irq_take  = timer_interrupt & mie_mtie & (mstatus_mie | (priv_mode == 2'b00)) & irq_pc_valid;
  assign trap_base = {mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
  assign trap_target = (trap_cause[XLEN-1] && mtvec[1:0] == 2'b01) ?
                       trap_base + XLEN'(4 * MTI_CODE) : trap_base;
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec[1:0];
  assign trap_target       = trap_base;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      trap_enter     <= 1'b0;
      trap_cause     <= '0;
      trap_pc        <= '0;
      trap_val       <= '0;
      mret_exec      <= 1'b0;
      flush          <= 1'b0;
      busy           <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      trap_enter <= 1'b0;
      mret_exec  <= 1'b0;
      case (state)
        IDLE: begin
          if (exc_valid) begin
            state      <= TRAP;
            trap_enter <= 1'b1;
            trap_cause <= exc_cause;
            trap_pc    <= exc_pc;
            trap_val   <= exc_tval;
            busy       <= 1'b1;
            flush      <= 1'b1;
          end else if (mret_req) begin
            state     <= MRET;
            mret_exec <= 1'b1;
            busy      <= 1'b1;
            flush     <= 1'b1;
          end else if (irq_take) begin
            state      <= TRAP;
            trap_enter <= 1'b1;
            trap_cause <= {1'b1, (XLEN-1)'(MTI_CODE)};
            trap_pc    <= irq_pc;
            trap_val   <= '0;
            busy       <= 1'b1;
            flush      <= 1'b1;
          end
        end
        TRAP: begin
          state          <= REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= trap_target;
        end
        MRET: begin
          state          <= REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= mepc;
        end
        REDIRECT: begin
          // redirect_pc stays put until fetch takes it
          if (redirect_ready) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            busy           <= 1'b0;
            flush          <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized bench for trap_ctrl against a request-timeline reference model,
// plus directed scenarios for the priority, masking, stall, vectoring and reset cases.
module tb_trap_ctrl;
  localparam int XLEN = 32;
  localparam int MTI  = 7;

  logic clk = 1'b0, rst = 1'b1;
  logic exc_valid = 0, mret_req = 0, irq_pc_valid = 0, timer_interrupt = 0;
  logic mie_mtie = 0, mstatus_mie = 0, redirect_ready = 1;
  logic [1:0] priv_mode = 2'd3;
  logic [XLEN-1:0] exc_cause = '0, exc_pc = '0, exc_tval = '0, irq_pc = '0, mtvec = '0, mepc = '0;
  logic trap_enter, mret_exec, flush, busy, redirect_valid;
  logic [XLEN-1:0] trap_cause, trap_pc, trap_val, redirect_pc;

  trap_ctrl #(.XLEN(XLEN), .MTI_CODE(MTI)) dut (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .exc_tval(exc_tval), .mret_req(mret_req), .irq_pc_valid(irq_pc_valid), .irq_pc(irq_pc),
    .timer_interrupt(timer_interrupt), .mie_mtie(mie_mtie), .mstatus_mie(mstatus_mie),
    .priv_mode(priv_mode), .mtvec(mtvec), .mepc(mepc), .trap_enter(trap_enter),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val), .mret_exec(mret_exec),
    .flush(flush), .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one outstanding request; m_age = cycles since it was accepted.
  bit              m_busy = 0, m_mret = 0;
  int              m_age  = 0;
  logic [XLEN-1:0] m_cause = '0, m_pc = '0, m_val = '0, m_rpc = '0;

  function automatic logic [XLEN-1:0] trap_dest(input logic [XLEN-1:0] tv, input logic [XLEN-1:0] cause);
    logic [XLEN-1:0] base;
    base = tv & ~32'h3;
`ifdef TRAP_CTRL_VECTORED_EN
    if (cause[XLEN-1] && tv[1:0] == 2'b01) return base + 4 * MTI;
`endif
    return base;
  endfunction

  task automatic check_outputs();
    chk("busy",        busy,           m_busy);
    chk("flush",       flush,          m_busy);
    chk("trap_enter",  trap_enter,     m_busy && m_age == 1 && !m_mret);
    chk("mret_exec",   mret_exec,      m_busy && m_age == 1 && m_mret);
    chk("redir_valid", redirect_valid, m_busy && m_age >= 2);
    chk("trap_cause",  trap_cause,     m_cause);
    chk("trap_pc",     trap_pc,        m_pc);
    chk("trap_val",    trap_val,       m_val);
    if (m_busy && m_age >= 2) chk("redir_pc", redirect_pc, m_rpc);
  endtask

  // One clock: capture inputs seen by the edge, advance the model, compare.
  task automatic step();
    bit irq, exc_s, mret_s, rdy_s;
    logic [XLEN-1:0] c_s, p_s, t_s, ipc_s, tv_s, mepc_s;
    irq    = timer_interrupt && mie_mtie && (mstatus_mie || priv_mode == 2'b00) && irq_pc_valid;
    exc_s  = exc_valid; mret_s = mret_req; rdy_s = redirect_ready;
    c_s    = exc_cause; p_s = exc_pc; t_s = exc_tval; ipc_s = irq_pc; tv_s = mtvec; mepc_s = mepc;
    @(posedge clk); #1;
    if (!m_busy) begin
      if (exc_s) begin
        m_busy = 1; m_age = 1; m_mret = 0; m_cause = c_s; m_pc = p_s; m_val = t_s;
      end else if (mret_s) begin
        m_busy = 1; m_age = 1; m_mret = 1;
      end else if (irq) begin
        m_busy = 1; m_age = 1; m_mret = 0; m_cause = 32'h8000_0000 + MTI; m_pc = ipc_s; m_val = '0;
      end
    end else if (m_age >= 2 && rdy_s) begin
      m_busy = 0;
    end else begin
      m_age++;
      if (m_age == 2) m_rpc = m_mret ? mepc_s : trap_dest(tv_s, m_cause);
    end
    check_outputs();
  endtask

  task automatic clr();
    exc_valid = 0; mret_req = 0; timer_interrupt = 0;
  endtask

  task automatic do_reset();
    rst = 1; #1;
    m_busy = 0; m_age = 0; m_cause = '0; m_pc = '0; m_val = '0; m_rpc = '0;
    chk("rst_busy", busy, 0); chk("rst_flush", flush, 0); chk("rst_te", trap_enter, 0);
    chk("rst_me", mret_exec, 0); chk("rst_rv", redirect_valid, 0); chk("rst_rpc", redirect_pc, 0);
    chk("rst_cause", trap_cause, 0); chk("rst_pc", trap_pc, 0); chk("rst_val", trap_val, 0);
    rst = 0;
  endtask

  initial begin
    #12; do_reset();

    // exception with fixed values
    mtvec = 32'h8000_0000;
    exc_valid = 1; exc_cause = 2; exc_pc = 32'h100; exc_tval = 32'hDEAD_BEEF;
    step(); clr();
    chk("s1_te", trap_enter, 1); chk("s1_cause", trap_cause, 2); chk("s1_tval", trap_val, 32'hDEAD_BEEF);
    step(); chk("s1_rpc", redirect_pc, 32'h8000_0000);
    step(); chk("s1_idle", busy, 0);

    // exception + mret + enabled timer together; interrupt follows after return
    mie_mtie = 1; mstatus_mie = 1; priv_mode = 3; irq_pc_valid = 1; irq_pc = 32'h44;
    exc_valid = 1; exc_cause = 2; mret_req = 1; timer_interrupt = 1;
    step(); exc_valid = 0; mret_req = 0;
    chk("s2_te", trap_enter, 1); chk("s2_me", mret_exec, 0); chk("s2_cause", trap_cause, 2);
    step(); step(); step();
    chk("s2_irq_te", trap_enter, 1); chk("s2_irq_cause", trap_cause, 32'h8000_0007);
    timer_interrupt = 0; step(); step(); step();

    // mret
    mepc = 32'h2000; mret_req = 1;
    step(); clr(); chk("s3_me", mret_exec, 1); chk("s3_te", trap_enter, 0);
    step(); chk("s3_rpc", redirect_pc, 32'h2000); chk("s3_me_once", mret_exec, 0);
    step();

    // masked in M-mode, taken in U-mode
    timer_interrupt = 1; mstatus_mie = 0; priv_mode = 3; irq_pc = 32'h40;
    step(); step(); chk("s4_masked", busy, 0);
    priv_mode = 0; step(); timer_interrupt = 0;
    chk("s4_te", trap_enter, 1); chk("s4_pc", trap_pc, 32'h40);
    step(); step(); priv_mode = 3;

    // fetch stalls the redirect; new exceptions are ignored meanwhile
    exc_valid = 1; exc_cause = 5; exc_pc = 32'h300; step();
    exc_cause = 6; redirect_ready = 0; step();
    for (int i = 0; i < 5; i++) begin
      step(); chk("s5_rv_hold", redirect_valid, 1); chk("s5_rpc_hold", redirect_pc, 32'h8000_0000);
    end
    exc_valid = 0; redirect_ready = 1; step(); chk("s5_idle", busy, 0);

    // vectored mtvec: interrupt vs exception
    mtvec = 32'h8000_0001; mstatus_mie = 1; timer_interrupt = 1;
    step(); timer_interrupt = 0; step();
`ifdef TRAP_CTRL_VECTORED_EN
    chk("s6_irq_rpc", redirect_pc, 32'h8000_001C);
`else
    chk("s6_irq_rpc", redirect_pc, 32'h8000_0000);
`endif
    step();
    exc_valid = 1; exc_cause = 1; step(); clr(); step();
    chk("s6_exc_rpc", redirect_pc, 32'h8000_0000);
    step();

    // reset while in TRAP
    exc_valid = 1; step(); clr(); chk("s7_in_trap", trap_enter, 1);
    do_reset(); step(); step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      exc_valid       = ($urandom_range(0, 5) == 0);
      mret_req        = ($urandom_range(0, 5) == 0);
      timer_interrupt = ($urandom_range(0, 3) == 0);
      mie_mtie        = $urandom_range(0, 1);
      mstatus_mie     = $urandom_range(0, 1);
      priv_mode       = $urandom_range(0, 1) ? 2'd3 : 2'd0;
      irq_pc_valid    = $urandom_range(0, 1);
      redirect_ready  = ($urandom_range(0, 2) != 0);
      exc_cause = $urandom_range(0, 15); exc_pc = $urandom; exc_tval = $urandom;
      irq_pc = $urandom; mepc = $urandom;
      mtvec = {$urandom_range(0, 65535), 14'h0, 2'($urandom_range(0, 3))};
      if (i % 500 == 250) do_reset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap/return sequencer sitting between the pipeline and the machine-mode CSR register file.
- Arbitrates synchronous exceptions, mret requests and the machine timer interrupt.
- Drives the CSR trap_enter/mret_exec strobes for exactly one cycle, flushes the pipeline and issues a held PC redirect to the fetch stage.

Parameters:
XLEN, 32, data/PC width
MTI_CODE, 7, mcause exception code used for machine timer interrupt

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
exc_valid  in  1  committing instruction raised exception
exc_cause  in  XLEN  exception mcause value (bit31=0)
exc_pc  in  XLEN  PC of faulting instruction
exc_tval  in  XLEN  mtval value for exception
mret_req  in  1  committing instruction is mret
irq_pc_valid  in  1  instruction boundary available; irq_pc is the next PC to execute
irq_pc  in  XLEN  PC saved to mepc on interrupt
timer_interrupt  in  1  level timer interrupt from timer block
mie_mtie  in  1  from CSR file
mstatus_mie  in  1  from CSR file
priv_mode  in  2  current privilege from CSR file (0=U, 3=M)
mtvec  in  XLEN  from CSR file
mepc  in  XLEN  from CSR file
trap_enter  out  1  one-cycle strobe to CSR file
trap_cause  out  XLEN  to CSR file
trap_pc  out  XLEN  to CSR file
trap_val  out  XLEN  to CSR file
mret_exec  out  1  one-cycle strobe to CSR file
flush  out  1  kill all in-flight instructions
busy  out  1  controller not IDLE; pipeline must stall commit
redirect_valid  out  1  new fetch PC valid
redirect_pc  out  XLEN  new fetch PC
redirect_ready  in  1  fetch accepted redirect

Behaviour:
- All outputs are registered. Reset: state=IDLE; all outputs 0.
- States: IDLE, TRAP, MRET, REDIRECT.
- irq_take = timer_interrupt & mie_mtie & (mstatus_mie | priv_mode==2'b00) & irq_pc_valid.
- IDLE priority, evaluated each cycle, exactly one winner:
  - exc_valid: latch cause/pc/tval, go to TRAP.
  - else mret_req: go to MRET.
  - else irq_take: latch cause={1'b1, MTI_CODE zero-extended}, pc=irq_pc, tval=0; go to TRAP.
- Simultaneous events: exception beats mret beats interrupt. The losing request is dropped; the flush kills its source, and a pending interrupt is re-evaluated on return to IDLE.
- TRAP, 1 cycle: trap_enter=1, trap_cause/pc/val stable, flush=1; next state REDIRECT.
- MRET, 1 cycle: mret_exec=1, flush=1; next state REDIRECT.
- REDIRECT: redirect_valid=1, flush=1.
  - redirect_pc after trap = {mtvec[XLEN-1:2], 2'b00}.
  - redirect_pc after mret = mepc.
  - redirect_pc is computed on entry to REDIRECT, after the CSR update, and held until redirect_ready.
  - On redirect_valid & redirect_ready: next state IDLE, redirect_valid drops the following cycle.
- Latency: request in IDLE at cycle N; strobe at N+1; redirect_valid at N+2; earliest return to IDLE at N+3.
- busy=1 whenever state != IDLE. Inputs are ignored outside IDLE.
- trap_cause/pc/val hold their last value outside TRAP. trap_enter and mret_exec are never high together and never high for more than 1 cycle per request.
- Reset mid-sequence: state returns to IDLE immediately; no strobe completes.

Optional Feature:
- Macro TRAP_CTRL_VECTORED_EN.
- Defined: if mtvec[1:0]==2'b01 and the trap is an interrupt, redirect_pc = {mtvec[XLEN-1:2],2'b00} + 4*MTI_CODE. Exceptions always use the base address.
- Undefined: mtvec[1:0] is ignored; all traps go to the base address.

Test Plan:
- exc_valid=1, cause=2, pc=0x100, tval=0xDEADBEEF, mtvec=0x8000_0000 → trap_enter at N+1 with those values; redirect_pc=0x8000_0000 at N+2; busy high N+1..until ready.
- exc_valid and mret_req and timer (enabled) in the same cycle → only trap_enter, cause=2. After return with MIE still 1, the interrupt is taken next: cause 0x8000_0007.
- mret_req=1, mepc=0x2000 → mret_exec pulse 1 cycle, no trap_enter, redirect_pc=0x2000.
- Timer pending, mie_mtie=1, mstatus_mie=0, priv=M → no trap. Same with priv=U → trap, trap_pc=irq_pc=0x40.
- redirect_ready held 0 for 5 cycles → redirect_valid/redirect_pc stable and flush=1 throughout; new exc_valid ignored; IDLE one cycle after ready.
- VECTORED_EN, mtvec=0x8000_0001, timer irq → redirect_pc=0x8000_001C; exception → 0x8000_0000. rst asserted in TRAP → all outputs 0 immediately.
